// File: rtl/nx_rbus_arb.sv
// Round-robin arbiter that shares one RBUS ring master port among N_REQ requesters,
// issuing one strobe per grant and routing the ring ack/err_ack (or a timeout) back.
module nx_rbus_arb #(
    parameter int unsigned N_REQ            = 4,
    parameter int unsigned N_RBUS_ADDR_BITS = 16,
    parameter int unsigned N_RBUS_DATA_BITS = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_valid_i,
    input  logic [N_REQ-1:0]                      req_wr_i,
    input  logic [N_REQ*N_RBUS_ADDR_BITS-1:0]     req_addr_i,
    input  logic [N_REQ*N_RBUS_DATA_BITS-1:0]     req_wr_data_i,
    output logic [N_REQ-1:0]                      req_ready_o,
    output logic [N_REQ-1:0]                      rsp_valid_o,
    output logic                                  rsp_err_o,
    output logic [N_RBUS_DATA_BITS-1:0]           rsp_rd_data_o,
    output logic [N_RBUS_ADDR_BITS-1:0]           rbus_addr_o,
    output logic                                  rbus_wr_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0]           rbus_wr_data_o,
    output logic                                  rbus_rd_strb_o,
    input  logic [N_RBUS_DATA_BITS-1:0]           rbus_rd_data_i,
    input  logic                                  rbus_ack_i,
    input  logic                                  rbus_err_ack_i,
    output logic                                  busy_o,
    output logic                                  timeout_o,
    output logic [7:0]                            stat_timeout_cnt_o,
    output logic [7:0]                            stat_stray_ack_cnt_o
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned STAT_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic [IDX_W-1:0]            win_q, win_d;
    logic                        wr_q, wr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [N_REQ-1:0]            req_ready_d, rsp_valid_d;
    logic                        rsp_err_d;
    logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data_d, rbus_wr_data_d;
    logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_d;
    logic                        rbus_wr_strb_d, rbus_rd_strb_d;
    logic                        busy_d, timeout_d;
    logic [STAT_W-1:0]           stat_timeout_d, stat_stray_d;

    logic                        grant_found_c;
    logic [IDX_W-1:0]            grant_idx_c, cand_c;
    logic                        any_ack_c;

    assign any_ack_c = rbus_ack_i | rbus_err_ack_i;

    // Circular search for the first valid requester after the previous winner.
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = IDX_W'((32'(last_grant_q) + k) % N_REQ);
            if (!grant_found_c && req_valid_i[cand_c]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = cand_c;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        win_d          = win_q;
        wr_d           = wr_q;
        cnt_d          = cnt_q;
        req_ready_d    = '0;
        rsp_valid_d    = '0;
        rsp_err_d      = 1'b0;
        rsp_rd_data_d  = '0;
        rbus_addr_d    = rbus_addr_o;
        rbus_wr_data_d = rbus_wr_data_o;
        rbus_wr_strb_d = 1'b0;
        rbus_rd_strb_d = 1'b0;
        timeout_d      = 1'b0;
        stat_timeout_d = stat_timeout_cnt_o;
        stat_stray_d   = stat_stray_ack_cnt_o;

        case (state_q)
            ST_IDLE: begin
                if (any_ack_c && stat_stray_ack_cnt_o != '1) begin
                    stat_stray_d = stat_stray_ack_cnt_o + 8'd1;
                end
                if (grant_found_c) begin
                    req_ready_d[grant_idx_c] = 1'b1;
                    rbus_wr_strb_d = req_wr_i[grant_idx_c];
                    rbus_rd_strb_d = !req_wr_i[grant_idx_c];
                    rbus_addr_d    = req_addr_i[32'(grant_idx_c) * N_RBUS_ADDR_BITS +: N_RBUS_ADDR_BITS];
                    rbus_wr_data_d = req_wr_i[grant_idx_c]
                                   ? req_wr_data_i[32'(grant_idx_c) * N_RBUS_DATA_BITS +: N_RBUS_DATA_BITS]
                                   : '0;
                    win_d          = grant_idx_c;
                    wr_d           = req_wr_i[grant_idx_c];
                    last_grant_d   = grant_idx_c;
                    cnt_d          = '0;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (any_ack_c) begin
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = rbus_err_ack_i;
                    rsp_rd_data_d      = wr_q ? '0 : rbus_rd_data_i;
                    state_d            = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    timeout_d          = 1'b1;
                    if (stat_timeout_cnt_o != '1) begin
                        stat_timeout_d = stat_timeout_cnt_o + 8'd1;
                    end
                    state_d            = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= ST_IDLE;
            last_grant_q         <= IDX_W'(N_REQ - 1);
            win_q                <= '0;
            wr_q                 <= 1'b0;
            cnt_q                <= '0;
            req_ready_o          <= '0;
            rsp_valid_o          <= '0;
            rsp_err_o            <= 1'b0;
            rsp_rd_data_o        <= '0;
            rbus_addr_o          <= '0;
            rbus_wr_strb_o       <= 1'b0;
            rbus_wr_data_o       <= '0;
            rbus_rd_strb_o       <= 1'b0;
            busy_o               <= 1'b0;
            timeout_o            <= 1'b0;
            stat_timeout_cnt_o   <= '0;
            stat_stray_ack_cnt_o <= '0;
        end else begin
            state_q              <= state_d;
            last_grant_q         <= last_grant_d;
            win_q                <= win_d;
            wr_q                 <= wr_d;
            cnt_q                <= cnt_d;
            req_ready_o          <= req_ready_d;
            rsp_valid_o          <= rsp_valid_d;
            rsp_err_o            <= rsp_err_d;
            rsp_rd_data_o        <= rsp_rd_data_d;
            rbus_addr_o          <= rbus_addr_d;
            rbus_wr_strb_o       <= rbus_wr_strb_d;
            rbus_wr_data_o       <= rbus_wr_data_d;
            rbus_rd_strb_o       <= rbus_rd_strb_d;
            busy_o               <= busy_d;
            timeout_o            <= timeout_d;
            stat_timeout_cnt_o   <= stat_timeout_d;
            stat_stray_ack_cnt_o <= stat_stray_d;
        end
    end

endmodule

// File: tb/tb_nx_rbus_arb.sv
// Directed bench for nx_rbus_arb: transaction-level reference model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_nx_rbus_arb;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_wr = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   rd_data = '0;
    logic            ack = 1'b0;
    logic            err_ack = 1'b0;

    logic [NR-1:0]   req_ready_o, rsp_valid_o;
    logic            rsp_err_o;
    logic [DW-1:0]   rsp_rd_data_o;
    logic [AW-1:0]   rbus_addr_o;
    logic            rbus_wr_strb_o, rbus_rd_strb_o;
    logic [DW-1:0]   rbus_wr_data_o;
    logic            busy_o, timeout_o;
    logic [7:0]      stat_timeout_cnt_o, stat_stray_ack_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    nx_rbus_arb #(
        .N_REQ(NR), .N_RBUS_ADDR_BITS(AW), .N_RBUS_DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr),
        .req_wr_data_i(req_wdata), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_err_o(rsp_err_o), .rsp_rd_data_o(rsp_rd_data_o), .rbus_addr_o(rbus_addr_o),
        .rbus_wr_strb_o(rbus_wr_strb_o), .rbus_wr_data_o(rbus_wr_data_o),
        .rbus_rd_strb_o(rbus_rd_strb_o), .rbus_rd_data_i(rd_data), .rbus_ack_i(ack),
        .rbus_err_ack_i(err_ack), .busy_o(busy_o), .timeout_o(timeout_o),
        .stat_timeout_cnt_o(stat_timeout_cnt_o), .stat_stray_ack_cnt_o(stat_stray_ack_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, timeout by elapsed edges since issue.
    logic [NR-1:0] e_ready, e_rsp_valid;
    logic          e_rsp_err, e_wstrb, e_rstrb, e_busy, e_timeout;
    logic [DW-1:0] e_rsp_data, e_wdata;
    logic [AW-1:0] e_addr;
    int            e_stat_to, e_stat_stray;
    bit            m_busy;
    bit            m_wr;
    int            m_owner, m_last, m_issue_ec;
    int            ec = 0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int off = 1; off <= NR; off++) begin
            int c;
            c = (last + off) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ready = '0; e_rsp_valid = '0; e_rsp_err = 1'b0; e_rsp_data = '0;
            e_addr = '0; e_wdata = '0; e_wstrb = 1'b0; e_rstrb = 1'b0;
            e_busy = 1'b0; e_timeout = 1'b0; e_stat_to = 0; e_stat_stray = 0;
            m_busy = 1'b0; m_wr = 1'b0; m_owner = 0; m_last = NR - 1; m_issue_ec = 0;
        end else begin
            int w;
            ec++;
            e_ready = '0; e_rsp_valid = '0; e_wstrb = 1'b0; e_rstrb = 1'b0; e_timeout = 1'b0;
            if (m_busy) begin
                if (ack || err_ack) begin
                    e_rsp_valid[m_owner] = 1'b1;
                    e_rsp_err = err_ack;
                    e_rsp_data = m_wr ? '0 : rd_data;
                    m_busy = 1'b0;
                end else if (ec - m_issue_ec == TO) begin
                    e_rsp_valid[m_owner] = 1'b1;
                    e_rsp_err = 1'b1;
                    e_rsp_data = '0;
                    e_timeout = 1'b1;
                    if (e_stat_to < 255) e_stat_to++;
                    m_busy = 1'b0;
                end
            end else begin
                if ((ack || err_ack) && e_stat_stray < 255) e_stat_stray++;
                w = rr_pick(req_valid, m_last);
                if (w >= 0) begin
                    e_ready[w] = 1'b1;
                    e_wstrb = req_wr[w];
                    e_rstrb = !req_wr[w];
                    e_addr = req_addr[w*AW +: AW];
                    e_wdata = req_wr[w] ? req_wdata[w*DW +: DW] : '0;
                    m_owner = w; m_wr = req_wr[w]; m_last = w; m_issue_ec = ec;
                    m_busy = 1'b1;
                end
            end
            e_busy = m_busy;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready_o), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp_valid));
        chk("rbus_addr", 32'(rbus_addr_o), 32'(e_addr));
        chk("rbus_wr_strb", 32'(rbus_wr_strb_o), 32'(e_wstrb));
        chk("rbus_rd_strb", 32'(rbus_rd_strb_o), 32'(e_rstrb));
        chk("rbus_wr_data", rbus_wr_data_o, e_wdata);
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("timeout", 32'(timeout_o), 32'(e_timeout));
        chk("stat_timeout", 32'(stat_timeout_cnt_o), 32'(e_stat_to));
        chk("stat_stray", 32'(stat_stray_ack_cnt_o), 32'(e_stat_stray));
        if (e_rsp_valid != '0) begin
            chk("rsp_err", 32'(rsp_err_o), 32'(e_rsp_err));
            chk("rsp_rd_data", rsp_rd_data_o, e_rsp_data);
        end
    end

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Raise one request in an IDLE cycle; returns in the strobe cycle S with valid dropped.
    task automatic issue(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_wr[idx] = wr;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = data;
        cyc(1);
        req_valid = '0;
    endtask

    // Called in S: drive the ring return during S+k, return in the response cycle S+k+1.
    task automatic ring_rsp(input int k, input bit a, input bit e, input logic [DW-1:0] d);
        cyc(k);
        ack = a; err_ack = e; rd_data = d;
        cyc(1);
        ack = 1'b0; err_ack = 1'b0; rd_data = '0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        cyc(3);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_addr", 32'(rbus_addr_o), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // All four requesters held valid: grants 0,1,2,3,0 spaced 4 cycles apart.
        req_wr = 4'b1010;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'(16'h1000 + i);
            req_wdata[i*DW +: DW] = DW'(32'h5000_0000 + i);
        end
        req_valid = 4'hF;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            logic [NR-1:0] oh;
            oh = '0;
            oh[i % NR] = 1'b1;
            chk("rr_ready", 32'(req_ready_o), 32'(oh));
            if (i == 4) req_valid = '0;
            cyc(2);
            ack = 1'b1; rd_data = DW'(32'hD000_0000 + i);
            cyc(1);
            ack = 1'b0; rd_data = '0;
            chk("rr_rsp", 32'(rsp_valid_o), 32'(oh));
            if (i == 0) chk("rr_rsp_data0", rsp_rd_data_o, 32'hD000_0000);
            cyc(1);
        end
        req_wr = '0;

        // Single read from requester 2, ack 5 cycles after the strobe.
        issue(2, 1'b0, 16'h0123, 32'h0);
        chk("rd_ready", 32'(req_ready_o), 32'h4);
        chk("rd_strb", 32'(rbus_rd_strb_o), 32'h1);
        chk("rd_addr", 32'(rbus_addr_o), 32'h0123);
        ring_rsp(5, 1'b1, 1'b0, 32'hCAFEF00D);
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'h4);
        chk("rd_rsp_data", rsp_rd_data_o, 32'hCAFEF00D);
        chk("rd_rsp_err", 32'(rsp_err_o), 32'h0);

        // Write from requester 1 answered by err_ack.
        issue(1, 1'b1, 16'h0BEE, 32'h12345678);
        chk("wr_strb", 32'(rbus_wr_strb_o), 32'h1);
        chk("wr_data", rbus_wr_data_o, 32'h12345678);
        ring_rsp(1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'h2);
        chk("wr_rsp_err", 32'(rsp_err_o), 32'h1);
        chk("wr_rsp_data", rsp_rd_data_o, 32'h0);

        // ack and err_ack together in the strobe cycle itself.
        issue(3, 1'b0, 16'h0333, 32'h0);
        ring_rsp(0, 1'b1, 1'b1, 32'hA5A5A5A5);
        chk("both_rsp_valid", 32'(rsp_valid_o), 32'h8);
        chk("both_err", 32'(rsp_err_o), 32'h1);
        chk("both_data", rsp_rd_data_o, 32'hA5A5A5A5);

        // Timeout, then a late ack three cycles later.
        issue(0, 1'b0, 16'h0040, 32'h0);
        cyc(TO - 1);
        chk("to_not_yet", 32'(rsp_valid_o), 32'h0);
        cyc(1);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("to_err", 32'(rsp_err_o), 32'h1);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_stat", 32'(stat_timeout_cnt_o), 32'h1);
        cyc(3);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("stray_cnt", 32'(stat_stray_ack_cnt_o), 32'h1);
        chk("stray_no_rsp", 32'(rsp_valid_o), 32'h0);

        // Saturate the timeout counter.
        for (int i = 0; i < 300; i++) begin
            issue(2, 1'b1, 16'h0200, 32'h0000_0200);
            cyc(TO);
        end
        chk("to_sat", 32'(stat_timeout_cnt_o), 32'hFF);

        // Reset mid-WAIT after requester 0 was the last grant.
        issue(0, 1'b0, 16'h0777, 32'h0);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_stat", 32'(stat_timeout_cnt_o), 32'h0);
        chk("mid_rst_addr", 32'(rbus_addr_o), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("post_rst_stray", 32'(stat_stray_ack_cnt_o), 32'h1);
        req_wr = '0;
        req_addr[0*AW +: AW] = 16'h0AA0;
        req_addr[1*AW +: AW] = 16'h0BB1;
        req_valid = 4'b0011;
        cyc(1);
        req_valid = '0;
        chk("post_rst_ready", 32'(req_ready_o), 32'h1);
        chk("post_rst_addr", 32'(rbus_addr_o), 32'h0AA0);
        ring_rsp(1, 1'b1, 1'b0, 32'h0BAD_F00D);
        chk("post_rst_rsp", 32'(rsp_valid_o), 32'h1);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nx_rbus_arb.md
# nx_rbus_arb

Round-robin arbiter and sequencer that shares a single RBUS ring master port among N_REQ local requesters (CSR engines, debug/JTAG bridge, firmware mailbox). Each granted request becomes exactly one single-cycle rd/wr strobe on the ring. The arbiter then waits for the ring-returned ack or err_ack, with a timeout, and routes the response back to the winning requester. It sits at the ring head, driving the inputs of the first ring stop and receiving the outputs of the last.

## Interface
- N_REQ, 4: number of requesters; 2..8.
- N_RBUS_ADDR_BITS, 16: ring address width.
- N_RBUS_DATA_BITS, 32: ring data width.
- TIMEOUT_CYCLES, 1024: WAIT cycles allowed before a timeout; 1..65535.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester request; held until matching req_ready_o pulse.
- req_wr_i  in  N_REQ  1=write, 0=read.
- req_addr_i  in  N_REQ*N_RBUS_ADDR_BITS  packed; requester i at [i*16 +: 16].
- req_wr_data_i  in  N_REQ*N_RBUS_DATA_BITS  packed; requester i at [i*32 +: 32].
- req_ready_o  out  N_REQ  one-cycle accept pulse, one-hot.
- rsp_valid_o  out  N_REQ  one-cycle response pulse, one-hot.
- rsp_err_o  out  1  error flag for the response; valid with rsp_valid_o.
- rsp_rd_data_o  out  N_RBUS_DATA_BITS  read data; valid with rsp_valid_o.
- rbus_addr_o  out  N_RBUS_ADDR_BITS  ring address.
- rbus_wr_strb_o  out  1  ring write strobe.
- rbus_wr_data_o  out  N_RBUS_DATA_BITS  ring write data.
- rbus_rd_strb_o  out  1  ring read strobe.
- rbus_rd_data_i  in  N_RBUS_DATA_BITS  ring return data.
- rbus_ack_i  in  1  ring return ack.
- rbus_err_ack_i  in  1  ring return error ack.
- busy_o  out  1  high when the FSM is not in IDLE.
- timeout_o  out  1  one-cycle pulse on timeout.
- stat_timeout_cnt_o  out  8  saturating count of timeouts.
- stat_stray_ack_cnt_o  out  8  saturating count of acks received outside WAIT.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Reset also clears internal state:
  - FSM = IDLE.
  - last_grant = N_REQ-1, so requester 0 wins first.
  - timeout counter = 0.
- FSM states are IDLE and WAIT.
- IDLE:
  - If any req_valid_i bit is set, the winner is the first set index searching circularly from last_grant+1.
  - Next cycle: req_ready_o[winner]=1, the rbus strobe is driven, and the FSM enters WAIT.
  - The strobe is rbus_wr_strb_o=req_wr_i[w] or rbus_rd_strb_o=!req_wr_i[w].
  - rbus_addr_o and rbus_wr_data_o take the winner's fields; for reads, rbus_wr_data_o=0.
  - Winner index and type are latched, last_grant=winner, counter=0.
  - Strobes are single-cycle. Address and data hold their value until the next issue.
- WAIT:
  - On rbus_ack_i or rbus_err_ack_i: next cycle rsp_valid_o[w]=1 and rsp_err_o=rbus_err_ack_i; the FSM returns to IDLE.
  - rsp_rd_data_o = rbus_rd_data_i for reads and 0 for writes.
  - When ack and err_ack arrive in the same cycle, error wins: rsp_err_o=1, data still captured.
  - When neither arrives: if counter==TIMEOUT_CYCLES-1, the next cycle drives rsp_valid_o[w]=1, rsp_err_o=1, rsp_rd_data_o=0 and timeout_o=1, increments stat_timeout_cnt_o, and returns to IDLE. Otherwise the counter increments.
- An ack or err_ack while in IDLE is a stray ack:
  - It is dropped and increments stat_stray_ack_cnt_o.
  - It covers a late ack after a timeout that arrives before the next issue.
  - The cycle in which an ack is accepted in WAIT is not stray.
- Statistics counters saturate at 8'hFF and are cleared only by reset.
- Requesters must hold req_valid_i and all their fields stable until req_ready_o. Deasserting req_valid_i before grant is legal and simply withdraws the request.
- Only one transaction is outstanding at a time.

## Timing
- Request sampled in IDLE at cycle T:
  - Strobe and req_ready_o at T+1. This cycle is S.
  - An ack at cycle S+k (0 ≤ k ≤ TIMEOUT_CYCLES-1) produces a response at S+k+1.
  - With no ack: timeout at S+TIMEOUT_CYCLES; rsp_valid_o and timeout_o are asserted that cycle.
- The response cycle is IDLE. A request sampled then issues its strobe the following cycle.
  - Back-to-back issue spacing is therefore 2 cycles plus the ring latency.
- busy_o is high from S through the last WAIT cycle, and low on the response cycle.
- Reset asserted mid-WAIT:
  - All outputs go to 0 immediately, with no response.
  - An ack arriving after reset release counts as stray.

## Test plan
- Single read, requester 2 only, addr 16'h0123, ring returns ack with data 32'hCAFEF00D 5 cycles after the strobe -> req_ready_o=4'b0100 at S, rbus_rd_strb_o=1 for one cycle, rsp_valid_o=4'b0100 with data CAFEF00D and rsp_err_o=0 at S+6.
- All 4 requesters held valid, ack 2 cycles after each strobe -> grants in order 0,1,2,3,0; each strobe 4 cycles apart; exactly one ready and one rsp bit set at any time.
- Write from requester 1, data 32'h12345678, err_ack returned -> rbus_wr_strb_o=1 with data 12345678, rsp_err_o=1, rsp_rd_data_o=0.
- TIMEOUT_CYCLES=16, no ack -> rsp_valid_o, rsp_err_o=1 and timeout_o at S+16; stat_timeout_cnt_o=1. A late ack 3 cycles later -> stat_stray_ack_cnt_o=1 and no rsp_valid_o.
- ack and err_ack together with data 32'hA5A5A5A5 -> rsp_err_o=1, data A5A5A5A5. 300 timeouts -> stat_timeout_cnt_o=8'hFF.
- rst_n pulsed low during WAIT -> all outputs 0 the same cycle. After release, requester 0 wins first even if last_grant was 0, and the next strobe issues normally.
